seg7_scan_disp: RTL and testbench

Downstream display stage of the NCO/counter/display chain. Takes six 4-bit digit codes, decimal-point and blank masks from the counter stage and time-multiplexes them onto a 6-digit common-anode 7-segment module. Includes double-buffered loading (no tearing mid-frame), anti-ghosting blank windows and a frame strobe. Runs on the 50 MHz system clock.

---
 rtl/seg7_scan_disp.sv | 213 +++++++++++++++++++++
 tb/tb_seg7_scan_disp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_disp.sv
// seg7_scan_disp: six-digit common-anode 7-segment scanner.
// Latches digit codes, decimal points and blank masks into a shadow
// buffer. The buffer goes live only at the frame boundary, so a frame
// never shows a mix of old and new data. The start of every digit slot
// is a dark window that suppresses ghosting.
// Ports:
//   clk, rst       : system clock; synchronous active-high reset
//   i_bcd[23:0]    : six 4-bit digit codes, digit 0 in bits [3:0]
//   i_dp[5:0]      : decimal-point enables, 1 = lit
//   i_blank[5:0]   : per-digit blank, 1 = dark
//   i_load         : one-cycle strobe that captures the three inputs above
//   o_seg[6:0]     : segments {a..g}, active-high
//   o_seg_dp       : decimal point, active-high
//   o_seg_enb[5:0] : digit enables, active-low, at most one low
//   o_frame        : one-cycle pulse on the first output cycle of digit 0
module seg7_scan_disp #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_bcd,
    input  logic [5:0]  i_dp,
    input  logic [5:0]  i_blank,
    input  logic        i_load,
    output logic [6:0]  o_seg,
    output logic        o_seg_dp,
    output logic [5:0]  o_seg_enb,
    output logic        o_frame
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   sh_bcd_q, sh_bcd_d;
    logic [5:0]    sh_dp_q, sh_dp_d;
    logic [5:0]    sh_blank_q, sh_blank_d;
    logic          pend_q, pend_d;
    logic [23:0]   act_bcd_q, act_bcd_d;
    logic [5:0]    act_dp_q, act_dp_d;
    logic [5:0]    act_blank_q, act_blank_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    enb_q, enb_d;
    logic          frame_q, frame_d;

    logic          slot_end;
    logic          xfer;
    logic [3:0]    dig;
    logic          dig_dp;
    logic          dig_blank;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    // Digit currently being scanned, taken from the live (active) buffer.
    always_comb begin
        dig       = 4'h0;
        dig_dp    = 1'b0;
        dig_blank = 1'b1;
        case (idx_q)
            3'd0: begin
                dig = act_bcd_q[3:0];
                dig_dp = act_dp_q[0];
                dig_blank = act_blank_q[0];
            end
            3'd1: begin
                dig = act_bcd_q[7:4];
                dig_dp = act_dp_q[1];
                dig_blank = act_blank_q[1];
            end
            3'd2: begin
                dig = act_bcd_q[11:8];
                dig_dp = act_dp_q[2];
                dig_blank = act_blank_q[2];
            end
            3'd3: begin
                dig = act_bcd_q[15:12];
                dig_dp = act_dp_q[3];
                dig_blank = act_blank_q[3];
            end
            3'd4: begin
                dig = act_bcd_q[19:16];
                dig_dp = act_dp_q[4];
                dig_blank = act_blank_q[4];
            end
            3'd5: begin
                dig = act_bcd_q[23:20];
                dig_dp = act_dp_q[5];
                dig_blank = act_blank_q[5];
            end
            default: begin
                dig = 4'h0;
                dig_dp = 1'b0;
                dig_blank = 1'b1;
            end
        endcase
    end

    assign slot_end = (cnt_q == CNT_LAST);
    assign xfer     = slot_end && (idx_q == 3'd5);

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        sh_bcd_d    = sh_bcd_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        pend_d      = pend_q;
        act_bcd_d   = act_bcd_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;

        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        if (i_load) begin
            sh_bcd_d   = i_bcd;
            sh_dp_d    = i_dp;
            sh_blank_d = i_blank;
            pend_d     = 1'b1;
        end

        // A load landing on the transfer edge bypasses the shadow so it
        // is not delayed by a whole frame. The transfer consumes it, so
        // pending clears here even when i_load is high.
        if (xfer) begin
            if (i_load) begin
                act_bcd_d   = i_bcd;
                act_dp_d    = i_dp;
                act_blank_d = i_blank;
            end else if (pend_q) begin
                act_bcd_d   = sh_bcd_q;
                act_dp_d    = sh_dp_q;
                act_blank_d = sh_blank_q;
            end
            pend_d = 1'b0;
        end

        seg_d   = 7'b0;
        dp_d    = 1'b0;
        enb_d   = 6'b111111;
        frame_d = (cnt_q == '0) && (idx_q == 3'd0);
        if ((cnt_q >= CNT_BLNK) && !dig_blank) begin
            seg_d = glyph(dig);
            dp_d  = dig_dp;
            enb_d = ~(6'b000001 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            sh_bcd_q    <= 24'h0;
            sh_dp_q     <= 6'h0;
            sh_blank_q  <= 6'h0;
            pend_q      <= 1'b0;
            act_bcd_q   <= 24'h0;
            act_dp_q    <= 6'h0;
            act_blank_q <= 6'b111111;
            seg_q       <= 7'b0;
            dp_q        <= 1'b0;
            enb_q       <= 6'b111111;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_bcd_q    <= sh_bcd_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            pend_q      <= pend_d;
            act_bcd_q   <= act_bcd_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            enb_q       <= enb_d;
            frame_q     <= frame_d;
        end
    end

    assign o_seg     = seg_q;
    assign o_seg_dp  = dp_q;
    assign o_seg_enb = enb_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_disp.sv
// tb_seg7_scan_disp: directed bench for seg7_scan_disp.
// Small scan (8 cycles/slot, 2 dark cycles); checks every output cycle.
module tb_seg7_scan_disp;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] i_bcd;
    logic [5:0]  i_dp;
    logic [5:0]  i_blank;
    logic        i_load;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [5:0]  o_seg_enb;
    logic        o_frame;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0]  gly [16];
    logic [23:0] e_bcd;
    logic [5:0]  e_dp;
    logic [5:0]  e_blank;

    int          n_ld;
    int          ld_c     [3];
    logic [23:0] ld_bcd   [3];
    logic [5:0]  ld_dp    [3];
    logic [5:0]  ld_blank [3];

    always #5 clk = ~clk;

    seg7_scan_disp #(
        .SCAN_DIV (8),
        .BLANK_CYC(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_bcd    (i_bcd),
        .i_dp     (i_dp),
        .i_blank  (i_blank),
        .i_load   (i_load),
        .o_seg    (o_seg),
        .o_seg_dp (o_seg_dp),
        .o_seg_enb(o_seg_enb),
        .o_frame  (o_frame)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of output cycle 0 of a frame; checks output
    // cycles 0..stop_c-1 and applies the queued loads on the way.
    task automatic run_frame(input string nm, input int stop_c);
        int         s;
        int         k;
        logic       lit;
        logic [5:0] x_enb;
        logic [6:0] x_seg;
        logic       x_dp;
        for (int c = 0; c < stop_c; c++) begin
            s = c / 8;
            k = c % 8;
            lit = (k >= 2) && !e_blank[s];
            x_enb = lit ? ~(6'b000001 << s) : 6'b111111;
            x_seg = lit ? gly[e_bcd[4*s +: 4]] : 7'b0;
            x_dp  = lit ? e_dp[s] : 1'b0;
            check($sformatf("%s c%0d enb", nm, c), 32'(o_seg_enb), 32'(x_enb));
            check($sformatf("%s c%0d seg", nm, c), 32'(o_seg), 32'(x_seg));
            check($sformatf("%s c%0d dp", nm, c), 32'(o_seg_dp), 32'(x_dp));
            check($sformatf("%s c%0d frame", nm, c), 32'(o_frame),
                  32'(c == 0));
            check($sformatf("%s c%0d onehot", nm, c),
                  32'($countones(~o_seg_enb) <= 1), 32'd1);
            i_load = 1'b0;
            for (int j = 0; j < n_ld; j++) begin
                if (ld_c[j] == c) begin
                    i_load  = 1'b1;
                    i_bcd   = ld_bcd[j];
                    i_dp    = ld_dp[j];
                    i_blank = ld_blank[j];
                end
            end
            @(negedge clk);
        end
        i_load = 1'b0;
        n_ld = 0;
    endtask

    task automatic add_ld(input int c, input logic [23:0] b,
                          input logic [5:0] d, input logic [5:0] bl);
        ld_c[n_ld]     = c;
        ld_bcd[n_ld]   = b;
        ld_dp[n_ld]    = d;
        ld_blank[n_ld] = bl;
        n_ld++;
    endtask

    initial begin
        gly[0]  = 7'b1111110; gly[1]  = 7'b0110000;
        gly[2]  = 7'b1101101; gly[3]  = 7'b1111001;
        gly[4]  = 7'b0110011; gly[5]  = 7'b1011011;
        gly[6]  = 7'b1011111; gly[7]  = 7'b1110000;
        gly[8]  = 7'b1111111; gly[9]  = 7'b1111011;
        gly[10] = 7'b1110111; gly[11] = 7'b0011111;
        gly[12] = 7'b1001110; gly[13] = 7'b0111101;
        gly[14] = 7'b1001111; gly[15] = 7'b1000111;
        n_ld = 0;

        rst = 1'b1;
        i_load = 1'b0;
        i_bcd = 24'h0;
        i_dp = 6'h0;
        i_blank = 6'h0;
        repeat (3) @(negedge clk);
        check("rst enb", 32'(o_seg_enb), 32'h3F);
        check("rst seg", 32'(o_seg), 32'h0);
        check("rst dp", 32'(o_seg_dp), 32'h0);
        check("rst frame", 32'(o_frame), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        e_bcd = 24'h0; e_dp = 6'h0; e_blank = 6'b111111;
        run_frame("f0", 48);

        add_ld(20, 24'h123456, 6'b000100, 6'b000000);
        run_frame("f1", 48);

        e_bcd = 24'h123456; e_dp = 6'b000100; e_blank = 6'b000000;
        add_ld(10, 24'hABCDEF, 6'b000000, 6'b100001);
        run_frame("f2", 48);

        e_bcd = 24'hABCDEF; e_dp = 6'b000000; e_blank = 6'b100001;
        add_ld(5, 24'h111111, 6'b000000, 6'b000000);
        add_ld(30, 24'h222222, 6'b000000, 6'b000000);
        add_ld(46, 24'h999999, 6'b000000, 6'b000000);
        run_frame("f3", 48);

        e_bcd = 24'h999999; e_dp = 6'b000000; e_blank = 6'b000000;
        run_frame("f4", 48);

        add_ld(10, 24'h123456, 6'b111111, 6'b000000);
        run_frame("f5", 28);
        rst = 1'b1;
        @(negedge clk);
        check("mrst enb", 32'(o_seg_enb), 32'h3F);
        check("mrst seg", 32'(o_seg), 32'h0);
        check("mrst dp", 32'(o_seg_dp), 32'h0);
        check("mrst frame", 32'(o_frame), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        e_bcd = 24'h0; e_dp = 6'h0; e_blank = 6'b111111;
        run_frame("f6", 48);
        run_frame("f7", 48);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
